apu_channel_mixer: RTL and testbench

Parametrised, time-multiplexed mixer for the audio processing unit. Replaces the fixed three-channel combinational sum with these features:
- N channels, each with a 4-bit volume register and an enable mask.
- Serial accumulation, one channel per clock.
- Output saturation, a valid strobe and overrun detection.

It sits between the channel generators (pulse/triangle/noise) and the DAC/PWM stage. One mix is produced per `i_sample_stb`.

---
 rtl/apu_pkg.sv | 14 +
 rtl/apu_channel_mixer_if.sv | 31 +++
 rtl/apu_volume_scaler.sv | 19 +
 rtl/apu_channel_mixer.sv | 145 ++++++++++++++
 tb/tb_apu_channel_mixer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/apu_pkg.sv
// Shared definitions for the APU channel mixer: FSM encodings and volume constants.
package apu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } mix_state_e;

  localparam int               VOL_W     = 4;
  localparam logic [VOL_W-1:0] VOL_UNITY = 4'd8;
  localparam int               VOL_SHIFT = 3;

endpackage

// File: rtl/apu_channel_mixer_if.sv
// Strobe, sample, volume-write and status bundle between the channel generators and the mixer.
interface apu_channel_mixer_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_W     = 9,
  parameter int OUT_W        = 10
);
  localparam int IDX_W = $clog2(NUM_CHANNELS);

  logic                             i_sample_stb;
  logic [NUM_CHANNELS*SAMPLE_W-1:0] i_channels;
  logic [NUM_CHANNELS-1:0]          i_mixer;
  logic                             i_vol_we;
  logic [IDX_W-1:0]                 i_vol_addr;
  logic [3:0]                       i_vol_data;
  logic [OUT_W-1:0]                 o_sample;
  logic                             o_sample_valid;
  logic                             o_clip;
  logic                             o_busy;
  logic                             o_overrun;

  modport master (
    output i_sample_stb, i_channels, i_mixer, i_vol_we, i_vol_addr, i_vol_data,
    input  o_sample, o_sample_valid, o_clip, o_busy, o_overrun
  );

  modport slave (
    input  i_sample_stb, i_channels, i_mixer, i_vol_we, i_vol_addr, i_vol_data,
    output o_sample, o_sample_valid, o_clip, o_busy, o_overrun
  );

endinterface

// File: rtl/apu_volume_scaler.sv
// Combinational sample x volume gain stage; the >>VOL_SHIFT truncates toward zero.
module apu_volume_scaler
  import apu_pkg::*;
#(
  parameter int SAMPLE_W = 9
) (
  input  logic [SAMPLE_W-1:0]                 i_sample,
  input  logic [VOL_W-1:0]                    i_vol,
  output logic [SAMPLE_W+VOL_W-VOL_SHIFT-1:0] o_scaled
);

  logic [SAMPLE_W+VOL_W-1:0] product;

  always_comb begin
    product  = {{VOL_W{1'b0}}, i_sample} * {{SAMPLE_W{1'b0}}, i_vol};
    o_scaled = product[SAMPLE_W+VOL_W-1:VOL_SHIFT];
  end

endmodule

// File: rtl/apu_channel_mixer.sv
// Time-multiplexed N-channel mixer: snapshots inputs on a strobe, accumulates one
// volume-scaled channel per clock, then emits a saturated sample with a valid pulse.
module apu_channel_mixer
  import apu_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_W     = 9,
  parameter int OUT_W        = 10
) (
  input  logic         i_clk,
  input  logic         i_reset,
  apu_channel_mixer_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_CHANNELS);
  localparam int ACC_W = SAMPLE_W + 1 + IDX_W;
  localparam int SCL_W = SAMPLE_W + VOL_W - VOL_SHIFT;

  localparam logic [ACC_W-1:0] OUT_MAX  = ACC_W'((64'd1 << OUT_W) - 64'd1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [VOL_W-1:0]    vol_t;

  mix_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  sample_t                 samp_snap_q [NUM_CHANNELS];
  sample_t                 samp_snap_d [NUM_CHANNELS];
  vol_t                    vol_snap_q  [NUM_CHANNELS];
  vol_t                    vol_snap_d  [NUM_CHANNELS];
  vol_t                    vol_q       [NUM_CHANNELS];
  vol_t                    vol_d       [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mask_snap_q, mask_snap_d;
  logic [OUT_W-1:0]        sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic                    clip_q, clip_d;
  logic                    overrun_q, overrun_d;

  sample_t                 chan_in [NUM_CHANNELS];
  logic [SCL_W-1:0]        scaled;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      chan_in[c] = bus.i_channels[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  // One scaler shared by every channel through the idx mux.
  apu_volume_scaler #(
    .SAMPLE_W (SAMPLE_W)
  ) u_scaler (
    .i_sample (samp_snap_q[idx_q]),
    .i_vol    (vol_snap_q[idx_q]),
    .o_scaled (scaled)
  );

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    samp_snap_d = samp_snap_q;
    vol_snap_d  = vol_snap_q;
    mask_snap_d = mask_snap_q;
    vol_d       = vol_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    clip_d      = clip_q;
    overrun_d   = overrun_q | (bus.i_sample_stb && (state_q != ST_IDLE));

    // Register writes land immediately; the mix reads only its snapshot.
    if (bus.i_vol_we && (int'(bus.i_vol_addr) < NUM_CHANNELS)) begin
      vol_d[bus.i_vol_addr] = bus.i_vol_data;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_sample_stb) begin
          samp_snap_d = chan_in;
          vol_snap_d  = vol_q;
          mask_snap_d = bus.i_mixer;
          acc_d       = '0;
          idx_d       = '0;
          state_d     = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (mask_snap_q[idx_q]) begin
          acc_d = acc_q + ACC_W'(scaled);
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_OUTPUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_OUTPUT: begin
        clip_d   = (acc_q > OUT_MAX);
        sample_d = clip_d ? OUT_W'(OUT_MAX) : OUT_W'(acc_q);
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      // NOTE: the volume array is reset because its power-on value (unity) is visible behaviour; the snapshots are reset only to keep simulation X-free.
      vol_q       <= '{default: VOL_UNITY};
      vol_snap_q  <= '{default: VOL_UNITY};
      samp_snap_q <= '{default: '0};
      mask_snap_q <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its inputs.
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      vol_q       <= vol_d;
      vol_snap_q  <= vol_snap_d;
      samp_snap_q <= samp_snap_d;
      mask_snap_q <= mask_snap_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      clip_q      <= clip_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.o_sample       = sample_q;
  assign bus.o_sample_valid = valid_q;
  assign bus.o_clip         = clip_q;
  assign bus.o_busy         = (state_q != ST_IDLE);
  assign bus.o_overrun      = overrun_q;

endmodule

// File: tb/tb_apu_channel_mixer.sv
// Directed-vector bench for apu_channel_mixer (4 channels, 9-bit samples, 10-bit output).
module tb_apu_channel_mixer;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  apu_channel_mixer_if #(.NUM_CHANNELS(4), .SAMPLE_W(9), .OUT_W(10)) bus ();

  apu_channel_mixer #(
    .NUM_CHANNELS (4),
    .SAMPLE_W     (9),
    .OUT_W        (10)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] pack4(input int a, input int b, input int c, input int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_vol(input logic [1:0] addr, input logic [3:0] data);
    @(negedge clk);
    bus.i_vol_we   = 1'b1;
    bus.i_vol_addr = addr;
    bus.i_vol_data = data;
    @(negedge clk);
    bus.i_vol_we   = 1'b0;
  endtask

  // Strobe once (optionally writing a volume on the strobe cycle) and watch 10 cycles.
  task automatic run_mix(input string tag, input logic [35:0] ch, input logic [3:0] m,
                         input logic we, input logic [1:0] wa, input logic [3:0] wd,
                         input int exp_sample, input int exp_clip);
    int   pulses;
    int   lat;
    logic [9:0] s;
    logic c;
    pulses = 0;
    lat    = 0;
    s      = '0;
    c      = 1'b0;
    @(negedge clk);
    bus.i_channels   = ch;
    bus.i_mixer      = m;
    bus.i_sample_stb = 1'b1;
    bus.i_vol_we     = we;
    bus.i_vol_addr   = wa;
    bus.i_vol_data   = wd;
    @(negedge clk);
    bus.i_sample_stb = 1'b0;
    bus.i_vol_we     = 1'b0;
    expect_eq({tag, "_busy_start"}, 32'(bus.o_busy), 32'd1);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 4) expect_eq({tag, "_busy_last"}, 32'(bus.o_busy), 32'd1);
      if (n == 5) expect_eq({tag, "_busy_done"}, 32'(bus.o_busy), 32'd0);
      if (bus.o_sample_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = n;
          s   = bus.o_sample;
          c   = bus.o_clip;
        end
      end
    end
    expect_eq({tag, "_sample"},  32'(s),      32'(exp_sample));
    expect_eq({tag, "_clip"},    32'(c),      32'(exp_clip));
    expect_eq({tag, "_pulses"},  32'(pulses), 32'd1);
    expect_eq({tag, "_latency"}, 32'(lat),    32'd5);
    expect_eq({tag, "_held"},    32'(bus.o_sample), 32'(exp_sample));
  endtask

  // Strobe at edge k and again at edge k+gap; count valid pulses over 22 cycles.
  task automatic strobe_pair(input string tag, input int gap, input int exp_pulses,
                             input int exp_overrun);
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.i_channels   = pack4(100, 200, 50, 7);
    bus.i_mixer      = 4'b1111;
    bus.i_sample_stb = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      if (bus.o_sample_valid) begin
        pulses++;
        expect_eq({tag, "_sample"}, 32'(bus.o_sample), 32'd357);
      end
      bus.i_sample_stb = (n == gap);
    end
    expect_eq({tag, "_pulses"},  32'(pulses),        32'(exp_pulses));
    expect_eq({tag, "_overrun"}, 32'(bus.o_overrun), 32'(exp_overrun));
  endtask

  initial begin
    int pulses;
    rst              = 1'b1;
    bus.i_sample_stb = 1'b0;
    bus.i_channels   = '0;
    bus.i_mixer      = '0;
    bus.i_vol_we     = 1'b0;
    bus.i_vol_addr   = '0;
    bus.i_vol_data   = '0;
    repeat (3) @(negedge clk);
    expect_eq("rst_sample",  32'(bus.o_sample),       32'd0);
    expect_eq("rst_valid",   32'(bus.o_sample_valid), 32'd0);
    expect_eq("rst_clip",    32'(bus.o_clip),         32'd0);
    expect_eq("rst_busy",    32'(bus.o_busy),         32'd0);
    expect_eq("rst_overrun", 32'(bus.o_overrun),      32'd0);
    rst = 1'b0;

    // Default unity volumes: plain sum.
    run_mix("sum4", pack4(100, 200, 50, 7), 4'b1111, 1'b0, 2'd0, 4'd0, 357, 0);

    // Per-channel volume and mask.
    write_vol(2'd1, 4'd4);
    write_vol(2'd2, 4'd0);
    run_mix("vol_mask", pack4(100, 200, 50, 7), 4'b1011, 1'b0, 2'd0, 4'd0, 207, 0);
    run_mix("mute_only", pack4(100, 200, 50, 7), 4'b0100, 1'b0, 2'd0, 4'd0, 0, 0);
    write_vol(2'd0, 4'd15);
    run_mix("trunc", pack4(100, 200, 50, 7), 4'b1001, 1'b0, 2'd0, 4'd0, 194, 0);
    run_mix("no_mask", pack4(100, 200, 50, 7), 4'b0000, 1'b0, 2'd0, 4'd0, 0, 0);

    // Saturation boundary.
    do_reset();
    run_mix("sat_edge", pack4(511, 511, 1, 0), 4'b1111, 1'b0, 2'd0, 4'd0, 1023, 0);
    run_mix("sat_over", pack4(511, 511, 2, 0), 4'b1111, 1'b0, 2'd0, 4'd0, 1023, 1);
    run_mix("unclip", pack4(1, 2, 3, 4), 4'b1111, 1'b0, 2'd0, 4'd0, 10, 0);
    for (int i = 0; i < 4; i++) write_vol(2'(i), 4'd15);
    run_mix("full_scale", pack4(511, 511, 511, 511), 4'b1111, 1'b0, 2'd0, 4'd0, 1023, 1);

    // Strobe spacing and sticky overrun.
    do_reset();
    strobe_pair("gap6", 6, 2, 0);
    strobe_pair("gap5", 5, 1, 1);
    do_reset();
    expect_eq("overrun_cleared", 32'(bus.o_overrun), 32'd0);
    strobe_pair("gap3", 3, 1, 1);

    // Volume write together with an accepted strobe.
    do_reset();
    run_mix("wr_old", pack4(100, 200, 50, 7), 4'b1111, 1'b1, 2'd0, 4'd0, 357, 0);
    run_mix("wr_new", pack4(100, 200, 50, 7), 4'b1111, 1'b0, 2'd0, 4'd0, 257, 0);

    // Reset while accumulating aborts the mix.
    @(negedge clk);
    bus.i_sample_stb = 1'b1;
    @(negedge clk);
    bus.i_sample_stb = 1'b0;
    @(negedge clk);
    expect_eq("abort_in_accum", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_eq("abort_sample",  32'(bus.o_sample),       32'd0);
    expect_eq("abort_valid",   32'(bus.o_sample_valid), 32'd0);
    expect_eq("abort_clip",    32'(bus.o_clip),         32'd0);
    expect_eq("abort_busy",    32'(bus.o_busy),         32'd0);
    expect_eq("abort_overrun", 32'(bus.o_overrun),      32'd0);
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.o_sample_valid) pulses++;
    end
    expect_eq("abort_no_pulse", 32'(pulses), 32'd0);
    run_mix("after_abort", pack4(100, 200, 50, 7), 4'b1111, 1'b0, 2'd0, 4'd0, 357, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
